// File: rtl/code_conv_pkg.sv
// Shared definitions for the Gray/binary conversion scheduler: FSM encoding,
// mode encoding and a binary-to-Gray reference helper.
package code_conv_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t CONV = 2'd1;
    localparam state_t HOLD = 2'd2;

    localparam logic MODE_B2G = 1'b0;
    localparam logic MODE_G2B = 1'b1;

    // Full 32-bit form; callers truncate to their own word width.
    function automatic logic [31:0] b2g(input logic [31:0] word);
        return word ^ (word >> 1);
    endfunction

endpackage

// File: rtl/code_conv_rr_arb.sv
// Two-way round-robin grant. Purely combinational; the last-grant history
// register lives in the parent.
module code_conv_rr_arb (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant,
    output logic       grant_idx
);

    always_comb begin
        grant_idx = 1'b0;
        case (valid)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last_grant;
            default: grant_idx = 1'b0;
        endcase
    end

    assign grant = (valid == 2'b00) ? 2'b00 : (grant_idx ? 2'b10 : 2'b01);

endmodule

// File: rtl/code_conv_sched.sv
// Shares one Gray/binary converter between two requesters: round-robin
// accept in IDLE, single-cycle B2G or bit-serial G2B in CONV, result held in HOLD.
module code_conv_sched
    import code_conv_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_mode,
    input  logic [WIDTH-1:0] req0_data,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_mode,
    input  logic [WIDTH-1:0] req1_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH);

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             last_grant_q;
    logic             mode_q;
    logic             src_q;
    logic [WIDTH-1:0] op_q;
    logic [WIDTH-1:0] res_q;

    logic [1:0]       grant;
    logic             grant_idx;
    logic             accept;
    logic [WIDTH-1:0] sel_data;
    logic             sel_mode;
    logic [WIDTH-1:0] res_shift;
    logic [WIDTH-1:0] g2b_next;
    logic             cnt_last;

    code_conv_rr_arb u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    assign req0_ready = (state_q == IDLE) & grant[0];
    assign req1_ready = (state_q == IDLE) & grant[1];
    assign accept     = (state_q == IDLE) & (|grant);
    assign sel_data   = grant_idx ? req1_data : req0_data;
    assign sel_mode   = grant_idx ? req1_mode : req0_mode;
    assign cnt_last   = (cnt_q == CW'(WIDTH - 1));

    // Bit (WIDTH-1-cnt) is resolved this edge; the MSB sees a zero from the shift.
    always_comb begin
        res_shift = res_q >> 1;
        g2b_next  = res_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (i == int'(WIDTH) - 1 - int'(cnt_q)) begin
                g2b_next[i] = res_shift[i] ^ op_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            mode_q       <= MODE_B2G;
            src_q        <= 1'b0;
            op_q         <= '0;
            res_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q         <= sel_data;
                        mode_q       <= sel_mode;
                        src_q        <= grant_idx;
                        last_grant_q <= grant_idx;
                        cnt_q        <= '0;
                        res_q        <= '0;
                        state_q      <= CONV;
                    end
                end
                CONV: begin
                    if (mode_q == MODE_B2G) begin
                        res_q   <= op_q ^ (op_q >> 1);
                        state_q <= HOLD;
                    end else begin
                        res_q <= g2b_next;
                        if (cnt_last) begin
                            cnt_q   <= '0;
                            state_q <= HOLD;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Partial G2B results stay hidden until the word is complete.
    assign out_valid = (state_q == HOLD);
    assign out_data  = out_valid ? res_q : '0;
    assign out_src   = out_valid & src_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_code_conv_sched.sv
// Directed bench for code_conv_sched: arbitration, latency, backpressure,
// asynchronous reset and an exhaustive 4-bit sweep with round trips.
module tb_code_conv_sched;
    import code_conv_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       req0_valid;
    logic       req0_ready;
    logic       req0_mode;
    logic [3:0] req0_data;
    logic       req1_valid;
    logic       req1_ready;
    logic       req1_mode;
    logic [3:0] req1_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       out_src;
    logic       busy;

    int n_checks;
    int n_pass;

    code_conv_sched #(
        .WIDTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_mode  (req0_mode),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_mode  (req1_mode),
        .req1_data  (req1_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_src    (out_src),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] g2b_ref(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic do_reset();
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Present a request on one port, expect its ready, complete the handshake.
    task automatic issue(input logic src, input logic mode, input logic [3:0] data);
        if (src) begin
            req1_valid = 1'b1; req1_mode = mode; req1_data = data;
        end else begin
            req0_valid = 1'b1; req0_mode = mode; req0_data = data;
        end
        #1;
        check("ready_granted", {31'd0, src ? req1_ready : req0_ready}, 32'd1);
        @(posedge clk);
        #1;
        if (src) req1_valid = 1'b0;
        else     req0_valid = 1'b0;
    endtask

    // Called just after the handshake edge; counts edges until out_valid.
    task automatic wait_out(input string tag, input logic [3:0] exp_data, input logic exp_src,
                            input int exp_lat);
        int   lat;
        logic rdy_seen;
        lat      = 0;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 20) begin
            if (req0_ready || req1_ready) rdy_seen = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_data"}, {28'd0, out_data}, {28'd0, exp_data});
        check({tag, "_src"}, {31'd0, out_src}, {31'd0, exp_src});
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        check({tag, "_no_ready"}, {31'd0, rdy_seen}, 32'd0);
    endtask

    task automatic drain(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_drain_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_drain_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic run_one(input logic src, input logic mode, input logic [3:0] data,
                           input logic [3:0] exp, output logic [3:0] got);
        issue(src, mode, data);
        wait_out(mode ? "g2b" : "b2g", exp, src, mode ? 4 : 1);
        got = out_data;
        drain("sweep");
    endtask

    initial begin
        logic [3:0] got;
        logic [3:0] enc;
        logic       flag;
        logic [3:0] hold_data;
        logic       hold_src;

        n_checks  = 0;
        n_pass    = 0;
        req0_mode = 1'b0; req0_data = '0;
        req1_mode = 1'b0; req1_data = '0;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #3;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {28'd0, out_data}, 32'd0);
        check("rst_out_src", {31'd0, out_src}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        do_reset();

        // 1: B2G from req0
        issue(1'b0, MODE_B2G, 4'b1011);
        check("t1_busy_conv", {31'd0, busy}, 32'd1);
        check("t1_valid_conv", {31'd0, out_valid}, 32'd0);
        wait_out("t1", 4'b1110, 1'b0, 1);
        drain("t1");

        // 2: G2B from req1 while req0 waits
        req0_valid = 1'b1; req0_mode = MODE_B2G; req0_data = 4'b0000;
        req1_valid = 1'b1; req1_mode = MODE_G2B; req1_data = 4'b1110;
        #1;
        check("t2_req0_blocked", {31'd0, req0_ready}, 32'd0);
        issue(1'b1, MODE_G2B, 4'b1110);
        wait_out("t2", 4'b1011, 1'b1, 4);
        drain("t2");
        issue(1'b0, MODE_B2G, 4'b0000);
        wait_out("t2b", 4'b0000, 1'b0, 1);
        drain("t2b");

        // 3: ties after reset
        do_reset();
        req0_valid = 1'b1; req0_mode = MODE_B2G; req0_data = 4'b0101;
        req1_valid = 1'b1; req1_mode = MODE_G2B; req1_data = 4'b0111;
        #1;
        check("t3_tie_r0", {31'd0, req0_ready}, 32'd1);
        check("t3_tie_r1", {31'd0, req1_ready}, 32'd0);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        wait_out("t3a", 4'b0111, 1'b0, 1);
        drain("t3a");
        check("t3_r1_now", {31'd0, req1_ready}, 32'd1);
        issue(1'b1, MODE_G2B, 4'b0111);
        wait_out("t3b", 4'b0101, 1'b1, 4);
        drain("t3b");
        req0_valid = 1'b1; req0_mode = MODE_B2G; req0_data = 4'b1001;
        req1_valid = 1'b1; req1_mode = MODE_B2G; req1_data = 4'b0110;
        #1;
        check("t3_retie_r0", {31'd0, req0_ready}, 32'd1);
        check("t3_retie_r1", {31'd0, req1_ready}, 32'd0);
        issue(1'b0, MODE_B2G, 4'b1001);
        wait_out("t3c", 4'b1101, 1'b0, 1);
        drain("t3c");
        issue(1'b1, MODE_B2G, 4'b0110);
        wait_out("t3d", 4'b0101, 1'b1, 1);
        drain("t3d");

        // 4: backpressure with req1 pending
        out_ready  = 1'b0;
        req1_valid = 1'b1; req1_mode = MODE_B2G; req1_data = 4'b0001;
        issue(1'b0, MODE_B2G, 4'b0011);
        req1_valid = 1'b1;
        wait_out("t4", 4'b0010, 1'b0, 1);
        hold_data = out_data;
        hold_src  = out_src;
        flag      = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (!out_valid || out_data != hold_data || out_src != hold_src || !busy ||
                req0_ready || req1_ready) flag = 1'b1;
        end
        check("t4_stable", {31'd0, flag}, 32'd0);
        check("t4_data_held", {28'd0, out_data}, 32'h2);
        out_ready = 1'b1;
        drain("t4");
        issue(1'b1, MODE_B2G, 4'b0001);
        wait_out("t4b", 4'b0001, 1'b1, 1);
        drain("t4b");

        // 5: asynchronous reset two edges into a G2B conversion
        issue(1'b0, MODE_G2B, 4'b1111);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_valid", {31'd0, out_valid}, 32'd0);
        check("t5_data", {28'd0, out_data}, 32'd0);
        check("t5_src", {31'd0, out_src}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        flag  = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (out_valid || busy) flag = 1'b1;
        end
        check("t5_no_stale", {31'd0, flag}, 32'd0);
        req0_valid = 1'b1; req0_mode = MODE_B2G; req0_data = 4'b1001;
        req1_valid = 1'b1; req1_mode = MODE_B2G; req1_data = 4'b0110;
        #1;
        check("t5_tie_r0", {31'd0, req0_ready}, 32'd1);
        check("t5_tie_r1", {31'd0, req1_ready}, 32'd0);
        issue(1'b0, MODE_B2G, 4'b1001);
        wait_out("t5a", 4'b1101, 1'b0, 1);
        drain("t5a");
        issue(1'b1, MODE_B2G, 4'b0110);
        wait_out("t5b", 4'b0101, 1'b1, 1);
        drain("t5b");

        // 6: exhaustive sweep and DUT round trip
        for (int v = 0; v < 16; v++) begin
            logic [3:0] val;
            val = 4'(v);
            run_one(val[0], MODE_B2G, val, 4'(b2g(32'(val))), enc);
            run_one(~val[0], MODE_G2B, enc, val, got);
            check("roundtrip", {28'd0, got}, {28'd0, val});
            run_one(val[0], MODE_G2B, val, g2b_ref(val), got);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
